grid_path_walker: RTL and testbench

- Sequential consumer of the shortest-path solver's result. Takes a 9-bit path cell mask plus source/destination on the 3x3 grid and replays the route as an ordered stream of nodes, one per valid/ready handshake.
- Each step carries a move direction, which lets downstream movers and displays follow the route.
- Sits directly after the path solver. Cell numbering is node = row*3 + col, with node 0 at top-left.

---
 rtl/grid_path_walker.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_grid_path_walker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_path_walker.sv
// grid_path_walker
//
// Replays a solved route on a 3x3 grid as an ordered stream of nodes.
// Node numbering is node = row*3 + col, with node 0 at the top-left.
// The route is given as a cell mask. The walker starts at the source and
// repeatedly steps to the lowest-numbered unvisited neighbour that is in the
// mask, until it reaches the destination or runs out of moves.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start        one-cycle request, only honoured while idle
//   path_mask    route cells (1 = on path); bit order set by PATH_BIT_REVERSED
//   source       first node of the walk (0-8)
//   destination  last node of the walk (0-8)
//   step_valid   step_node/step_dir/step_last are valid
//   step_ready   consumer accepts the current step
//   step_node    current route node
//   step_dir     move into step_node: 0=N, 1=E, 2=S, 3=W (0 on the first step)
//   step_last    step_node is the destination
//   step_count   handshakes completed in the current walk
//   busy         high whenever the walker is not idle
//   done         one-cycle pulse after a successful walk
//   error        one-cycle pulse when a walk is aborted
//   error_code   1=bad endpoint, 2=dead end, 3=unused mask cells; held until
//                the next start
module grid_path_walker #(
    parameter bit PATH_BIT_REVERSED = 1'b1,
    parameter bit CHECK_UNUSED      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] path_mask,
    input  logic [3:0] source,
    input  logic [3:0] destination,
    output logic       step_valid,
    input  logic       step_ready,
    output logic [3:0] step_node,
    output logic [1:0] step_dir,
    output logic       step_last,
    output logic [3:0] step_count,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_EMIT   = 3'd2;
    localparam logic [2:0] S_SEARCH = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [1:0] ERR_ENDPOINT = 2'd1;
    localparam logic [1:0] ERR_DEAD_END = 2'd2;
    localparam logic [1:0] ERR_UNUSED   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0] state_q, state_d;
    logic [8:0] mask_q, mask_d;         // cell-ordered: bit j = cell j
    logic [3:0] src_q, src_d;
    logic [3:0] dst_q, dst_d;
    logic [3:0] cur_q, cur_d;
    logic [1:0] dir_q, dir_d;
    logic [8:0] visited_q, visited_d;
    logic [3:0] count_q, count_d;
    logic [1:0] err_code_q, err_code_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [8:0] mask_norm;   // path_mask re-ordered so bit j is cell j
    logic [8:0] mv_n;        // cell j is reached from cur_q by a move north
    logic [8:0] mv_e;
    logic [8:0] mv_s;
    logic [8:0] mv_w;
    logic [8:0] cand;        // reachable, on path and not yet visited
    logic [3:0] pick;
    logic       pick_found;
    logic [1:0] pick_dir;
    logic       endpoint_bad;
    logic       unused_cells;
    logic       finish_fail;

    // One-hot bit for a node number; nodes above 8 map to no bit.
    function automatic logic [8:0] node_bit(input logic [3:0] n);
        logic [8:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            if (n == 4'(i)) begin
                b[i] = 1'b1;
            end
        end
        return b;
    endfunction

    // Per-cell neighbour relations to the current node. Each relation is
    // generated only where the grid edge allows it, so moves never wrap from
    // one row end to the next row.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            if (PATH_BIT_REVERSED) begin : g_rev
                assign mask_norm[gi] = path_mask[8-gi];
            end else begin : g_fwd
                assign mask_norm[gi] = path_mask[gi];
            end

            // Moving north into cell gi means cur_q sits directly below it.
            if (gi <= 5) begin : g_n
                assign mv_n[gi] = (cur_q == 4'(gi + 3));
            end else begin : g_no_n
                assign mv_n[gi] = 1'b0;
            end

            // Moving south into cell gi means cur_q sits directly above it.
            if (gi >= 3) begin : g_s
                assign mv_s[gi] = (cur_q == 4'(gi - 3));
            end else begin : g_no_s
                assign mv_s[gi] = 1'b0;
            end

            // Moving east into cell gi: cur_q is its left neighbour.
            if ((gi % 3) != 0) begin : g_e
                assign mv_e[gi] = (cur_q == 4'(gi - 1));
            end else begin : g_no_e
                assign mv_e[gi] = 1'b0;
            end

            // Moving west into cell gi: cur_q is its right neighbour.
            if ((gi % 3) != 2) begin : g_w
                assign mv_w[gi] = (cur_q == 4'(gi + 1));
            end else begin : g_no_w
                assign mv_w[gi] = 1'b0;
            end
        end
    endgenerate

    assign cand = (mv_n | mv_e | mv_s | mv_w) & mask_q & ~visited_q;

    // Lowest-numbered candidate wins: scan downwards so the last hit is the
    // smallest index.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            if (cand[i]) begin
                pick       = 4'(i);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_dir = DIR_W;
        if (mv_n[pick]) begin
            pick_dir = DIR_N;
        end else if (mv_e[pick]) begin
            pick_dir = DIR_E;
        end else if (mv_s[pick]) begin
            pick_dir = DIR_S;
        end
    end

    // Range checks come first so the mask lookups only matter for nodes 0-8.
    assign endpoint_bad = (src_q > 4'd8) || (dst_q > 4'd8)
                       || ((mask_q & node_bit(src_q)) == 9'd0)
                       || ((mask_q & node_bit(dst_q)) == 9'd0);

    assign unused_cells = |(mask_q & ~visited_q);
    assign finish_fail  = CHECK_UNUSED && unused_cells;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cur_d      = cur_q;
        dir_d      = dir_q;
        visited_d  = visited_q;
        count_d    = count_q;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d     = mask_norm;
                    src_d      = source;
                    dst_d      = destination;
                    visited_d  = '0;
                    count_d    = '0;
                    err_code_d = '0;
                    state_d    = S_CHECK;
                end
            end

            S_CHECK: begin
                if (endpoint_bad) begin
                    err_code_d = ERR_ENDPOINT;
                    state_d    = S_FAIL;
                end else begin
                    cur_d     = src_q;
                    dir_d     = DIR_N;
                    visited_d = node_bit(src_q);
                    state_d   = S_EMIT;
                end
            end

            S_EMIT: begin
                // Outputs are taken straight from the registers, so they stay
                // stable for as long as the consumer stalls.
                if (step_ready) begin
                    count_d = count_q + 4'd1;
                    state_d = (cur_q == dst_q) ? S_FINISH : S_SEARCH;
                end
            end

            S_SEARCH: begin
                if (pick_found) begin
                    cur_d     = pick;
                    dir_d     = pick_dir;
                    visited_d = visited_q | node_bit(pick);
                    state_d   = S_EMIT;
                end else begin
                    err_code_d = ERR_DEAD_END;
                    state_d    = S_FAIL;
                end
            end

            S_FINISH: begin
                if (finish_fail) begin
                    err_code_d = ERR_UNUSED;
                    state_d    = S_FAIL;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_FAIL: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            cur_q      <= '0;
            dir_q      <= '0;
            visited_q  <= '0;
            count_q    <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cur_q      <= cur_d;
            dir_q      <= dir_d;
            visited_q  <= visited_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign step_valid = (state_q == S_EMIT);
    assign step_node  = cur_q;
    assign step_dir   = dir_q;
    assign step_last  = step_valid && (cur_q == dst_q);
    assign step_count = count_q;
    assign busy       = (state_q != S_IDLE);
    // done and error come from mutually exclusive states, so they can never
    // be high together.
    assign done       = (state_q == S_FINISH) && !finish_fail;
    assign error      = (state_q == S_FAIL);
    assign error_code = err_code_q;

endmodule

// File: tb/tb_grid_path_walker.sv
// Directed bench for grid_path_walker: a table of walks with hand-derived
// node/direction sequences and outcome codes, plus hand-written sequences
// for backpressure and mid-walk reset. A second instance with the unused-cell
// check disabled runs on the same stimulus.
module tb_grid_path_walker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] path_mask;
    logic [3:0] source;
    logic [3:0] destination;
    logic       step_ready;

    logic       step_valid, step_last, busy, done, error;
    logic [3:0] step_node, step_count;
    logic [1:0] step_dir, error_code;

    logic       b_step_valid, b_step_last, b_busy, b_done, b_error;
    logic [3:0] b_step_node, b_step_count;
    logic [1:0] b_step_dir, b_error_code;

    always #5 clk = ~clk;

    grid_path_walker dut (
        .clk(clk), .reset(rst_n), .start(start), .path_mask(path_mask),
        .source(source), .destination(destination),
        .step_valid(step_valid), .step_ready(step_ready),
        .step_node(step_node), .step_dir(step_dir), .step_last(step_last),
        .step_count(step_count), .busy(busy), .done(done), .error(error),
        .error_code(error_code)
    );

    grid_path_walker #(.PATH_BIT_REVERSED(1'b1), .CHECK_UNUSED(1'b0)) dut_nc (
        .clk(clk), .reset(rst_n), .start(start), .path_mask(path_mask),
        .source(source), .destination(destination),
        .step_valid(b_step_valid), .step_ready(step_ready),
        .step_node(b_step_node), .step_dir(b_step_dir), .step_last(b_step_last),
        .step_count(b_step_count), .busy(b_busy), .done(b_done), .error(b_error),
        .error_code(b_error_code)
    );

    // cells: bit j = cell j. nodes/dirs: one hex digit per step, first step
    // in the most significant used digit.
    typedef struct {
        logic [8:0]  cells;
        logic [3:0]  src;
        logic [3:0]  dst;
        int          n;
        logic [35:0] nodes;
        logic [35:0] dirs;
        int          code;
    } vec_t;

    vec_t vecs[11];
    vec_t rst_vec;

    int checks = 0;
    int errors = 0;

    int obs_n, a_done_n, a_err_n, b_done_n, b_err_n, a_code, b_code;
    int stall_n, together_n;
    bit walk_ended;
    int obs_node[9];
    int obs_dir[9];
    int obs_last[9];
    int obs_cyc[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Solver ordering: path_mask[8-j] holds cell j.
    function automatic logic [8:0] rev9(input logic [8:0] c);
        logic [8:0] r;
        for (int j = 0; j < 9; j++) r[8-j] = c[j];
        return r;
    endfunction

    // Called on a falling edge. Runs one walk, stalling step_ready for
    // stall_len cycles the first time stall_node is offered.
    task automatic run_walk(input logic [8:0] cells, input logic [3:0] src,
                            input logic [3:0] dst, input int stall_node,
                            input int stall_len);
        int held_node, held_dir;
        obs_n = 0; a_done_n = 0; a_err_n = 0; b_done_n = 0; b_err_n = 0;
        a_code = 0; b_code = 0; stall_n = 0; together_n = 0;
        walk_ended = 1'b0; held_node = 0; held_dir = 0;
        path_mask = rev9(cells); source = src; destination = dst;
        step_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_t1", int'(busy), 1);
        chk("valid_t1", int'(step_valid), 0);
        for (int cyc = 0; cyc < 80 && !walk_ended; cyc++) begin
            if (done) a_done_n++;
            if (error) begin a_err_n++; a_code = int'(error_code); end
            if (done && error) together_n++;
            if (b_done) b_done_n++;
            if (b_error) begin b_err_n++; b_code = int'(b_error_code); end
            if (step_valid) begin
                if (int'(step_node) == stall_node && stall_n < stall_len) begin
                    if (stall_n == 0) begin
                        held_node = int'(step_node);
                        held_dir  = int'(step_dir);
                    end else begin
                        chk("hold_node", int'(step_node), held_node);
                        chk("hold_dir", int'(step_dir), held_dir);
                    end
                    stall_n++;
                    step_ready = 1'b0;
                end else begin
                    step_ready = 1'b1;
                    if (obs_n < 9) begin
                        obs_node[obs_n] = int'(step_node);
                        obs_dir[obs_n]  = int'(step_dir);
                        obs_last[obs_n] = int'(step_last);
                        obs_cyc[obs_n]  = cyc;
                    end
                    obs_n++;
                end
            end else begin
                step_ready = 1'b1;
            end
            if (done || error) walk_ended = 1'b1;
            @(negedge clk);
        end
        step_ready = 1'b1;
        chk("walk_ended", int'(walk_ended), 1);
        chk("busy_idle", int'(busy), 0);
        chk("valid_idle", int'(step_valid), 0);
    endtask

    task automatic check_vec(input vec_t v, input int idx, input bit timing);
        string t;
        logic [35:0] nds, drs;
        bit reach;
        t = $sformatf("v%0d", idx);
        nds = v.nodes;
        drs = v.dirs;
        reach = (v.code == 0 || v.code == 3);
        chk({t, "_nsteps"}, obs_n, v.n);
        for (int i = 0; i < v.n && i < obs_n && i < 9; i++) begin
            chk($sformatf("%s_node%0d", t, i), obs_node[i], int'(nds[4*(v.n-1-i) +: 4]));
            chk($sformatf("%s_dir%0d", t, i), obs_dir[i], int'(drs[4*(v.n-1-i) +: 4]));
            chk($sformatf("%s_last%0d", t, i), obs_last[i], (reach && i == v.n - 1) ? 1 : 0);
            if (timing) begin
                if (i == 0) chk({t, "_first_lat"}, obs_cyc[0], 1);
                else chk($sformatf("%s_gap%0d", t, i), obs_cyc[i] - obs_cyc[i-1], 2);
            end
        end
        chk({t, "_done"}, a_done_n, (v.code == 0) ? 1 : 0);
        chk({t, "_error"}, a_err_n, (v.code != 0) ? 1 : 0);
        chk({t, "_code"}, a_code, v.code);
        chk({t, "_code_hold"}, int'(error_code), v.code);
        chk({t, "_count"}, int'(step_count), v.n);
        chk({t, "_excl"}, together_n, 0);
        chk({t, "_nc_done"}, b_done_n, reach ? 1 : 0);
        chk({t, "_nc_error"}, b_err_n, reach ? 0 : 1);
        chk({t, "_nc_code"}, b_code, (v.code == 3) ? 0 : v.code);
        chk({t, "_nc_count"}, int'(b_step_count), v.n);
        $display("walk %s src=%0d dst=%0d steps=%0d code=%0d done=%0d count=%0d",
                 t, v.src, v.dst, obs_n, a_code, a_done_n, step_count);
    endtask

    initial begin
        vecs[0]  = '{9'b100100111, 4'd0, 4'd8, 5, 36'h01258,     36'h01122,     0}; // straight
        vecs[1]  = '{9'b000100111, 4'd0, 4'd8, 0, 36'h0,         36'h0,         1}; // dst not in mask
        vecs[2]  = '{9'b100010011, 4'd0, 4'd8, 3, 36'h014,       36'h012,       2}; // dead end
        vecs[3]  = '{9'b001000111, 4'd0, 4'd2, 3, 36'h012,       36'h011,       3}; // unused cell 6
        vecs[4]  = '{9'b100111001, 4'd8, 4'd0, 5, 36'h85430,     36'h00330,     0}; // N and W moves
        vecs[5]  = '{9'b111111111, 4'd9, 4'd0, 0, 36'h0,         36'h0,         1}; // source > 8
        vecs[6]  = '{9'b111111111, 4'd0, 4'd15, 0, 36'h0,        36'h0,         1}; // destination > 8
        vecs[7]  = '{9'b000000110, 4'd0, 4'd2, 0, 36'h0,         36'h0,         1}; // src not in mask
        vecs[8]  = '{9'b000011011, 4'd4, 4'd0, 3, 36'h410,       36'h003,       3}; // lowest candidate
        vecs[9]  = '{9'b000101100, 4'd2, 4'd3, 2, 36'h25,        36'h02,        2}; // no row wrap
        vecs[10] = '{9'b111111111, 4'd0, 4'd8, 9, 36'h012543678, 36'h011233211, 0}; // 9-step snake
        rst_vec  = '{9'b000010000, 4'd4, 4'd4, 1, 36'h4,         36'h0,         0}; // src == dst

        rst_n = 1'b0; start = 1'b0; path_mask = '0; source = '0;
        destination = '0; step_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", int'(step_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(step_count), 0);
        chk("rst_code", int'(error_code), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 11; k++) begin
            run_walk(vecs[k].cells, vecs[k].src, vecs[k].dst, -1, 0);
            check_vec(vecs[k], k, 1'b1);
            @(negedge clk);
        end

        // Backpressure: hold node 2 for three cycles.
        run_walk(vecs[0].cells, vecs[0].src, vecs[0].dst, 2, 3);
        chk("bp_stall_cycles", stall_n, 3);
        check_vec(vecs[0], 100, 1'b0);
        @(negedge clk);

        // Mid-walk reset while a step is being offered.
        path_mask = rev9(vecs[0].cells); source = 4'd0; destination = 4'd8;
        step_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && !(step_valid && step_node == 4'd5); k++) @(negedge clk);
        step_ready = 1'b0;
        chk("mr_pre_valid", int'(step_valid), 1);
        chk("mr_pre_node", int'(step_node), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", int'(step_valid), 0);
        chk("mr_node", int'(step_node), 0);
        chk("mr_dir", int'(step_dir), 0);
        chk("mr_last", int'(step_last), 0);
        chk("mr_count", int'(step_count), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_error", int'(error), 0);
        chk("mr_code", int'(error_code), 0);
        $display("mid-walk reset applied");
        @(negedge clk);
        rst_n = 1'b1;
        step_ready = 1'b1;
        @(negedge clk);
        chk("mr_idle_busy", int'(busy), 0);
        chk("mr_idle_valid", int'(step_valid), 0);

        run_walk(rst_vec.cells, rst_vec.src, rst_vec.dst, -1, 0);
        check_vec(rst_vec, 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
